// File: rtl/eq_cmp_pkg.sv
// Shared types for the output-stream equivalence comparator: FSM states and failure codes.
package eq_cmp_pkg;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PASS,
        ST_FAIL
    } state_e;

    localparam logic [2:0] FC_NONE  = 3'd0;
    localparam logic [2:0] FC_DATA  = 3'd1;
    localparam logic [2:0] FC_OVF_A = 3'd2;
    localparam logic [2:0] FC_OVF_B = 3'd3;
    localparam logic [2:0] FC_LEN   = 3'd4;

endpackage

// File: rtl/eq_out_stream_cmp_if.sv
// Output-side AXI-stream signals of the two models plus their completion levels.
interface eq_out_stream_cmp_if #(
    parameter int DATA_W = 8
) ();

    logic              arg_0_TREADY;
    logic [DATA_W-1:0] a_arg_0_TDATA;
    logic              a_arg_0_TVALID;
    logic [DATA_W-1:0] b_arg_0_TDATA;
    logic              b_arg_0_TVALID;
    logic              a_complete;
    logic              b_complete;

    modport master (
        output arg_0_TREADY, a_arg_0_TDATA, a_arg_0_TVALID,
               b_arg_0_TDATA, b_arg_0_TVALID, a_complete, b_complete
    );

    modport slave (
        input  arg_0_TREADY, a_arg_0_TDATA, a_arg_0_TVALID,
               b_arg_0_TDATA, b_arg_0_TVALID, a_complete, b_complete
    );

endinterface

// File: rtl/eq_sync_fifo.sv
// First-word fall-through synchronous FIFO; pointers carry one extra wrap bit.
module eq_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_en, rd_en;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    // a simultaneous pop frees the slot, so a push on full is legal then
    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/eq_out_stream_cmp.sv
// Aligns the A and B model output streams through skew FIFOs and compares them beat by beat.
module eq_out_stream_cmp
    import eq_cmp_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 19,
    parameter int NUM_PIX = 307200
) (
    input  logic               clk,
    input  logic               rst_init,
    eq_out_stream_cmp_if.slave strm,
    output logic               cmp_pass,
    output logic               cmp_fail,
    output logic [2:0]         fail_code,
    output logic [CNT_W-1:0]   cmp_cnt,
    output logic [CNT_W-1:0]   bad_idx,
    output logic [DATA_W-1:0]  bad_a,
    output logic [DATA_W-1:0]  bad_b
);

    localparam logic [CNT_W-1:0] NUM_PIX_C = CNT_W'(NUM_PIX);

    state_e            state_q, state_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic [2:0]        code_q, code_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] ba_q, ba_d;
    logic [DATA_W-1:0] bb_q, bb_d;

    logic              running, pop;
    logic              push_a_req, push_b_req, ovf_a, ovf_b;
    logic              empty_a, empty_b, full_a, full_b;
    logic [DATA_W-1:0] head_a, head_b;
    logic              both_done, at_len, data_bad, len_bad, pass_ok;
    logic [2:0]        code_now;

    assign running    = (state_q == ST_RUN);
    assign push_a_req = strm.a_arg_0_TVALID & strm.arg_0_TREADY & running;
    assign push_b_req = strm.b_arg_0_TVALID & strm.arg_0_TREADY & running;
    assign pop        = running & ~empty_a & ~empty_b;
    assign ovf_a      = push_a_req & full_a & ~pop;
    assign ovf_b      = push_b_req & full_b & ~pop;

    eq_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_a (
        .clk  (clk),
        .rst  (rst_init),
        .push (push_a_req & ~ovf_a),
        .din  (strm.a_arg_0_TDATA),
        .pop  (pop),
        .dout (head_a),
        .empty(empty_a),
        .full (full_a)
    );

    eq_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_b (
        .clk  (clk),
        .rst  (rst_init),
        .push (push_b_req & ~ovf_b),
        .din  (strm.b_arg_0_TDATA),
        .pop  (pop),
        .dout (head_b),
        .empty(empty_b),
        .full (full_b)
    );

    assign both_done = strm.a_complete & strm.b_complete;
    assign at_len    = (cnt_q == NUM_PIX_C);
    assign data_bad  = pop & (head_a != head_b);
    assign len_bad   = (pop & at_len)
                     | (both_done & empty_a & empty_b & ~at_len)
                     | (both_done & (empty_a ^ empty_b));
    assign pass_ok   = both_done & empty_a & empty_b & at_len;

    always_comb begin
        code_now = FC_NONE;
        if (ovf_a)         code_now = FC_OVF_A;
        else if (ovf_b)    code_now = FC_OVF_B;
        else if (data_bad) code_now = FC_DATA;
        else if (len_bad)  code_now = FC_LEN;
    end

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        ba_d    = ba_q;
        bb_d    = bb_q;
        if (running) begin
            if (pop && !at_len) cnt_d = cnt_q + CNT_W'(1);
            if (code_now != FC_NONE) begin
                state_d = ST_FAIL;
                fail_d  = 1'b1;
                code_d  = code_now;
                idx_d   = cnt_q;
                if (code_now == FC_DATA) begin
                    ba_d = head_a;
                    bb_d = head_b;
                end
            end else if (pass_ok) begin
                state_d = ST_PASS;
                pass_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_init) begin
            state_q <= ST_RUN;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            code_q  <= FC_NONE;
            cnt_q   <= '0;
            idx_q   <= '0;
            ba_q    <= '0;
            bb_q    <= '0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ba_q    <= ba_d;
            bb_q    <= bb_d;
        end
    end

    assign cmp_pass  = pass_q;
    assign cmp_fail  = fail_q;
    assign fail_code = code_q;
    assign cmp_cnt   = cnt_q;
    assign bad_idx   = idx_q;
    assign bad_a     = ba_q;
    assign bad_b     = bb_q;

endmodule

// File: tb/tb_eq_out_stream_cmp.sv
// Bench for eq_out_stream_cmp: two instances (NUM_PIX 4 and 8) against a queue-based reference model.
module tb_eq_out_stream_cmp;

    localparam int DEPTH = 16;

    typedef logic [7:0] beats_t [$];
    typedef enum {M_RUN, M_PASS, M_FAIL} mst_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    eq_out_stream_cmp_if #(.DATA_W(8)) bus ();

    logic        p4, f4, p8, f8;
    logic [2:0]  c4, c8;
    logic [18:0] n4, n8, i4, i8;
    logic [7:0]  a4, b4, a8, b8;

    eq_out_stream_cmp #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(19), .NUM_PIX(4)) dut4 (
        .clk(clk), .rst_init(rst), .strm(bus),
        .cmp_pass(p4), .cmp_fail(f4), .fail_code(c4), .cmp_cnt(n4),
        .bad_idx(i4), .bad_a(a4), .bad_b(b4)
    );

    eq_out_stream_cmp #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(19), .NUM_PIX(8)) dut8 (
        .clk(clk), .rst_init(rst), .strm(bus),
        .cmp_pass(p8), .cmp_fail(f8), .fail_code(c8), .cmp_cnt(n8),
        .bad_idx(i8), .bad_a(a8), .bad_b(b8)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc_n = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: the FIFOs hold identical contents for every instance still running,
    // so one pair of queues serves both; only counters and verdicts are per instance.
    logic [7:0]  qa[$], qb[$];
    int unsigned m_np[2] = '{4, 8};
    mst_t        m_st[2];
    int unsigned m_cnt[2], m_code[2], m_idx[2];
    logic [7:0]  m_ba[2], m_bb[2];

    task automatic model_step();
        bit pop, pa, pb, oa, ob, any_run, done, len, ea, eb;
        int unsigned code;
        if (rst) begin
            qa.delete();
            qb.delete();
            for (int i = 0; i < 2; i++) begin
                m_st[i] = M_RUN; m_cnt[i] = 0; m_code[i] = 0; m_idx[i] = 0;
                m_ba[i] = '0; m_bb[i] = '0;
            end
            return;
        end
        ea   = (qa.size() == 0);
        eb   = (qb.size() == 0);
        pop  = !ea && !eb;
        pa   = bus.a_arg_0_TVALID && bus.arg_0_TREADY;
        pb   = bus.b_arg_0_TVALID && bus.arg_0_TREADY;
        oa   = pa && (qa.size() == DEPTH) && !pop;
        ob   = pb && (qb.size() == DEPTH) && !pop;
        done = bus.a_complete && bus.b_complete;
        any_run = 0;
        for (int i = 0; i < 2; i++) begin
            if (m_st[i] == M_RUN) begin
                any_run = 1;
                len = (pop && m_cnt[i] == m_np[i]) || (done && ea && eb && m_cnt[i] != m_np[i])
                      || (done && (ea != eb));
                code = 0;
                if (oa) code = 2;
                else if (ob) code = 3;
                else if (pop && (qa[0] != qb[0])) code = 1;
                else if (len) code = 4;
                if (code != 0) begin
                    m_st[i] = M_FAIL; m_code[i] = code; m_idx[i] = m_cnt[i];
                    if (code == 1) begin
                        m_ba[i] = qa[0];
                        m_bb[i] = qb[0];
                    end
                end else if (done && ea && eb && m_cnt[i] == m_np[i]) begin
                    m_st[i] = M_PASS;
                end
                if (pop && m_cnt[i] < m_np[i]) m_cnt[i]++;
            end
        end
        if (any_run) begin
            if (pop) begin
                void'(qa.pop_front());
                void'(qb.pop_front());
            end
            if (pa && !oa) qa.push_back(bus.a_arg_0_TDATA);
            if (pb && !ob) qb.push_back(bus.b_arg_0_TDATA);
        end
    endtask

    function automatic logic [63:0] exp_vec(input int i);
        return {5'b0, m_st[i] == M_PASS, m_st[i] == M_FAIL, 3'(m_code[i]),
                19'(m_cnt[i]), 19'(m_idx[i]), m_ba[i], m_bb[i]};
    endfunction

    function automatic logic [63:0] dut_vec(input int i);
        if (i == 0) return {5'b0, p4, f4, c4, n4, i4, a4, b4};
        return {5'b0, p8, f8, c8, n8, i8, a8, b8};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc_n++;
        check($sformatf("dut4_c%0d", cyc_n), dut_vec(0), exp_vec(0));
        check($sformatf("dut8_c%0d", cyc_n), dut_vec(1), exp_vec(1));
        check($sformatf("excl_c%0d", cyc_n), {62'b0, p4 & f4, p8 & f8}, 64'd0);
    endtask

    task automatic idle_inputs();
        bus.arg_0_TREADY   = 1'b1;
        bus.a_arg_0_TVALID = 1'b0;
        bus.b_arg_0_TVALID = 1'b0;
        bus.a_arg_0_TDATA  = '0;
        bus.b_arg_0_TDATA  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        bus.a_complete = 1'b0;
        bus.b_complete = 1'b0;
        tick();
        rst = 1'b0;
        check("rst_dut4", dut_vec(0), 64'd0);
        check("rst_dut8", dut_vec(1), 64'd0);
    endtask

    task automatic run_stream(input beats_t ad, input beats_t bd,
                              input int unsigned a_start, input int unsigned b_start,
                              input int unsigned gap_pct, input int unsigned rdy_pct,
                              input bit complete, input int unsigned tail);
        int unsigned ia = 0, ib = 0, cyc = 0;
        bit av, bv, rdy;
        while ((ia < ad.size() || ib < bd.size()) && cyc < 2000) begin
            av  = (ia < ad.size()) && (cyc >= a_start) && ($urandom_range(0, 99) >= gap_pct);
            bv  = (ib < bd.size()) && (cyc >= b_start) && ($urandom_range(0, 99) >= gap_pct);
            rdy = ($urandom_range(0, 99) < rdy_pct);
            bus.arg_0_TREADY   = rdy;
            bus.a_arg_0_TVALID = av;
            bus.b_arg_0_TVALID = bv;
            bus.a_arg_0_TDATA  = av ? ad[ia] : 8'($urandom);
            bus.b_arg_0_TDATA  = bv ? bd[ib] : 8'($urandom);
            tick();
            if (av && rdy) ia++;
            if (bv && rdy) ib++;
            cyc++;
        end
        check("stream_budget", {63'b0, (ia == ad.size()) && (ib == bd.size())}, 64'd1);
        idle_inputs();
        if (complete) begin
            bus.a_complete = 1'b1;
            bus.b_complete = 1'b1;
        end
        repeat (tail) tick();
    endtask

    initial begin
        beats_t ad, bd;
        int unsigned n, k, lead;
        idle_inputs();
        bus.a_complete = 1'b0;
        bus.b_complete = 1'b0;

        // T1: four identical beats, same cycles
        do_reset();
        ad = '{8'd10, 8'd20, 8'd30, 8'd40};
        run_stream(ad, ad, 0, 0, 0, 100, 1, 5);
        check("t1_pass4", {63'b0, p4}, 64'd1);
        check("t1_cnt4", {45'b0, n4}, 64'd4);
        check("t1_code8", {61'b0, c8}, 64'd4);

        // T2: A leads B by ten cycles
        do_reset();
        ad = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        run_stream(ad, ad, 0, 10, 0, 100, 1, 5);
        check("t2_pass8", {63'b0, p8}, 64'd1);
        check("t2_code8", {61'b0, c8}, 64'd0);
        check("t2_cnt8", {45'b0, n8}, 64'd8);

        // T3: third beat differs
        do_reset();
        ad = '{8'h01, 8'h02, 8'h55, 8'h04};
        bd = '{8'h01, 8'h02, 8'h56, 8'h04};
        run_stream(ad, bd, 0, 0, 0, 100, 1, 5);
        check("t3_code", {61'b0, c4}, 64'd1);
        check("t3_idx", {45'b0, i4}, 64'd2);
        check("t3_bad_a", {56'b0, a4}, 64'h55);
        check("t3_bad_b", {56'b0, b4}, 64'h56);

        // T4: B silent, A overflows its FIFO on the 17th push
        do_reset();
        ad.delete();
        for (int i = 0; i < 17; i++) ad.push_back(8'(i + 1));
        bd.delete();
        run_stream(ad, bd, 0, 0, 0, 100, 0, 2);
        check("t4_code4", {61'b0, c4}, 64'd2);
        check("t4_code8", {61'b0, c8}, 64'd2);

        // T5: one pair too many
        do_reset();
        ad = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5};
        run_stream(ad, ad, 0, 0, 0, 100, 1, 5);
        check("t5_code", {61'b0, c4}, 64'd4);
        check("t5_idx", {45'b0, i4}, 64'd4);

        // T6: reset mid-frame, then a fresh frame
        do_reset();
        ad = '{8'd7, 8'd8};
        run_stream(ad, ad, 0, 0, 0, 100, 0, 2);
        check("t6_mid_cnt", {45'b0, n4}, 64'd2);
        do_reset();
        ad = '{8'd11, 8'd22, 8'd33, 8'd44};
        run_stream(ad, ad, 0, 0, 0, 100, 1, 5);
        check("t6_pass", {63'b0, p4}, 64'd1);

        // randomized frames: skew, gaps, backpressure, occasional corruption
        for (int t = 0; t < 24; t++) begin
            do_reset();
            n = $urandom_range(1, 20);
            ad.delete();
            for (int i = 0; i < int'(n); i++) ad.push_back(8'($urandom));
            bd = ad;
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(0, n - 1);
                bd[k] = bd[k] ^ 8'($urandom_range(1, 255));
            end
            lead = $urandom_range(0, 20);
            if ($urandom_range(0, 1) == 1)
                run_stream(ad, bd, lead, 0, $urandom_range(0, 40), $urandom_range(60, 100), 1, 30);
            else
                run_stream(ad, bd, 0, lead, $urandom_range(0, 40), $urandom_range(60, 100), 1, 30);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
